// File: rtl/da_lut_loader_pkg.sv
// Shared constants and state encoding for the distributed-arithmetic LUT loader.
package da_pkg;

   localparam int NTAPS     = 64;
   localparam int GROUP     = 8;
   localparam int NGROUPS   = 8;
   localparam int COEF_W    = 17;
   localparam int LUT_W     = 20;
   localparam int ADDR_W    = 11;
   localparam int LUT_DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      STREAM  = 2'd1,
      DONE_ST = 2'd2
   } state_e;

endpackage

// File: rtl/da_lut_loader_if.sv
// Coefficient-load, control and LUT-stream signals between the loader and its neighbours.
interface da_lut_loader_if;
   import da_pkg::*;

   logic                     coef_wr;
   logic [5:0]               coef_addr;
   logic signed [COEF_W-1:0] coef_in;
   logic                     start;
   logic                     busy;
   logic                     done;
   logic                     filter_en;
   logic signed [LUT_W-1:0]  CIN;
   logic [ADDR_W-1:0]        CADDR;
   logic                     CLOAD;

   modport master (
      output coef_wr, coef_addr, coef_in, start,
      input  busy, done, filter_en, CIN, CADDR, CLOAD
   );

   modport slave (
      input  coef_wr, coef_addr, coef_in, start,
      output busy, done, filter_en, CIN, CADDR, CLOAD
   );

endinterface

// File: rtl/da_lut_loader_group_sum.sv
// Combinational masked sum of one group of eight coefficients, sign-extended to LUT width.
module da_group_sum #(
   parameter int DATA_W = da_pkg::LUT_W,
   parameter int COEF_W = da_pkg::COEF_W
) (
   input  logic [da_pkg::GROUP-1:0][COEF_W-1:0] coef,
   input  logic [da_pkg::GROUP-1:0]             mask,
   output logic signed [DATA_W-1:0]             sum
);

   // Widen a coefficient so eight of them can be added without overflow.
   function automatic logic signed [DATA_W-1:0] sext(input logic [COEF_W-1:0] c);
      return {{(DATA_W-COEF_W){c[COEF_W-1]}}, c};
   endfunction

   // Add every coefficient whose mask bit is set; an empty mask yields zero.
   always_comb begin
      sum = '0;
      for (int b = 0; b < da_pkg::GROUP; b++) begin
         if (mask[b]) begin
            sum = sum + sext(coef[b]);
         end
      end
   end

endmodule

// File: rtl/da_lut_loader.sv
// Builds the 2048-word distributed-arithmetic LUT from 64 tap coefficients and
// streams it to the filter, one registered word per clock.
module da_lut_loader
   import da_pkg::*;
(
   input logic            clk_slow,
   input logic            reset,
   da_lut_loader_if.slave bus
);

   state_e                       state_q;
   state_e                       state_d;
   logic [ADDR_W-1:0]            cnt_p0;
   logic [ADDR_W-1:0]            cnt_nxt;
   logic signed [LUT_W-1:0]      cin_p0;
   logic signed [LUT_W-1:0]      grp_sum;
   logic                         done_p0;
   logic                         vld_p0;
   logic signed [COEF_W-1:0]     coef_q [NTAPS];
   logic [GROUP-1:0][COEF_W-1:0] grp_coef;
   logic                         cfg_open;
   logic                         accept;
   logic                         last_word;
   logic                         advance;

   // Coefficients and start are only honoured while no stream is in flight.
   assign cfg_open  = (state_q == IDLE) || (state_q == DONE_ST);
   assign accept    = cfg_open && bus.start;
   assign last_word = (state_q == STREAM) && (cnt_p0 == ADDR_W'(LUT_DEPTH - 1));
   assign advance   = (state_q == STREAM) && !last_word;

   // State register.
   always_ff @(posedge clk_slow) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode: one pass of 2048 words per accepted start.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.start) state_d = STREAM;
         STREAM:  if (last_word) state_d = DONE_ST;
         DONE_ST: if (bus.start) state_d = STREAM;
         default: state_d = IDLE;
      endcase
   end

   // Next address: restart at 0 on accept, step while streaming, hold at 2047 afterwards.
   always_comb begin
      cnt_nxt = cnt_p0;
      if (accept) begin
         cnt_nxt = '0;
      end else if (advance) begin
         cnt_nxt = cnt_p0 + 1'b1;
      end
   end

   // Gather the group addressed by the next word so CIN is registered alongside CADDR.
   always_comb begin
      for (int b = 0; b < GROUP; b++) begin
         grp_coef[b] = coef_q[{cnt_nxt[ADDR_W-1:8], 3'(b)}];
      end
   end

   da_group_sum #(
      .DATA_W (LUT_W),
      .COEF_W (COEF_W)
   ) u_group_sum (
      .coef (grp_coef),
      .mask (cnt_nxt[7:0]),
      .sum  (grp_sum)
   );

   // ---- stage p0: address/word registers presented to the filter ----
   // Address counter and LUT word, cleared by reset so a partial stream leaves no residue.
   always_ff @(posedge clk_slow) begin
      if (reset) begin
         cnt_p0 <= '0;
         cin_p0 <= '0;
      end else begin
         cnt_p0 <= cnt_nxt;
         if (accept || advance) begin
            cin_p0 <= grp_sum;
         end
      end
   end

   // Done pulse: raised only by the natural end of a stream, never by reset.
   always_ff @(posedge clk_slow) begin
      if (reset) begin
         done_p0 <= 1'b0;
      end else begin
         done_p0 <= last_word;
      end
   end

   // Coefficient register file; a write coinciding with start still lands before it is needed.
   always_ff @(posedge clk_slow) begin
      if (reset) begin
         for (int i = 0; i < NTAPS; i++) begin
            coef_q[i] <= '0;
         end
      end else if (bus.coef_wr && cfg_open) begin
         coef_q[bus.coef_addr] <= bus.coef_in;
      end
   end

   // Outputs decoded from state so CLOAD and filter_en can never overlap.
   always_comb begin
      vld_p0        = (state_q == STREAM);
      bus.CLOAD     = vld_p0;
      bus.busy      = vld_p0;
      bus.filter_en = (state_q == DONE_ST);
      bus.done      = done_p0;
      bus.CIN       = cin_p0;
      bus.CADDR     = cnt_p0;
   end

endmodule
